// File: rtl/tx_msg_scheduler.sv
// tx_msg_scheduler: round-robin arbiter streaming memory-resident messages
// from two requesters to a UART byte transmitter.
module tx_msg_scheduler #(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic [1:0]        gnt,
    output logic              done0,
    output logic              done1,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, WAIT_HI, WAIT_LO, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              last;
    logic              pick;
    logic [LEN_W-1:0]  sel_len;
    // On a tie the requester not served last wins; last resets to 1 so requester 0 wins first.
    assign pick     = (req0 & req1) ? ~last : req1;
    assign sel_len  = pick ? len1 : len0;
    assign mem_addr = cur_addr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            done0     <= 1'b0;
            done1     <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            cur_addr  <= '0;
            remaining <= '0;
            last      <= 1'b1;
        end else begin
            tx_start <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            case (state)
                IDLE: if (req0 | req1) begin
                    gnt       <= pick ? 2'b10 : 2'b01;
                    cur_addr  <= pick ? addr1 : addr0;
                    remaining <= sel_len;
                    state     <= (sel_len == '0) ? DONE : FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    tx_data <= mem_data;
                    state   <= START;
                end
                START: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    state    <= WAIT_HI;
                end
                WAIT_HI: if (tx_busy) state <= WAIT_LO;
                WAIT_LO: if (!tx_busy) begin
                    remaining <= remaining - 1'b1;
                    cur_addr  <= cur_addr + 1'b1;
                    state     <= (remaining == LEN_W'(1)) ? DONE : FETCH;
                end
                DONE: begin
                    done0 <= gnt[0];
                    done1 <= gnt[1];
                    last  <= gnt[1];
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
